// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared core types: controller state encoding and NOP instruction.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MDU_WAIT = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use hazard decode between ID and EX.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_is_load_i,
  output logic       lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is never a real producer, so a load into x0 cannot create a hazard
  assign lu_o = id_valid_i && ex_valid_i && ex_is_load_i && (ex_rd_i != 5'd0)
                && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with saturating stall counter.
// Multi-cycle MDU wait support is built only when PIPELINE_CTRL_MDU_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_valid,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_is_load,
  input  logic                   ex_redirect,
  input  logic                   mdu_start,
  input  logic                   mdu_done,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};

  state_e                   state_q, state_d;
  logic [FLUSH_CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [STALL_CNT_W-1:0]   stall_q, stall_d;
  logic                     lu;
  logic                     mdu_start_eff;
  logic                     mdu_done_eff;

`ifdef PIPELINE_CTRL_MDU_EN
  assign mdu_start_eff = mdu_start;
  assign mdu_done_eff  = mdu_done;
`else
  logic unused_mdu;
  assign unused_mdu    = mdu_start ^ mdu_done;
  assign mdu_start_eff = 1'b0;
  assign mdu_done_eff  = 1'b0;
`endif

  hazard_detect u_hazard_detect (
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_valid_i    (ex_valid),
    .ex_rd_i       (ex_rd),
    .ex_is_load_i  (ex_is_load),
    .lu_o          (lu)
  );

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;

    // A taken redirect wins over every other event in every state
    if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = FLUSH;
      fcnt_d      = FLUSH_LOAD;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (mdu_start_eff) begin
            state_d = MDU_WAIT;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          if (fcnt_q == '0) begin
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        MDU_WAIT: begin
          if (mdu_done_eff) begin
            state_d = RUN;
          end else begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (FLUSH_CYCLES=3/W=4 and FLUSH_CYCLES=1/W=16).
module tb_pipeline_ctrl;

  localparam logic [4:0] O_RUN = 5'b11100;
  localparam logic [4:0] O_LU  = 5'b00101;
  localparam logic [4:0] O_RD  = 5'b11111;
  localparam logic [4:0] O_FL  = 5'b11110;
  localparam logic [4:0] O_MW  = 5'b00000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load;
  logic       ex_redirect, mdu_start, mdu_done;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        pc_en0, if_id_en0, id_ex_en0, if_id_flush0, id_ex_flush0;
  logic [3:0]  stall_cnt0;
  logic [1:0]  state0;
  logic        pc_en1, if_id_en1, id_ex_en1, if_id_flush1, id_ex_flush1;
  logic [15:0] stall_cnt1;
  logic [1:0]  state1;

  typedef struct packed {
    logic [4:0] o;
    logic [1:0] st;
    logic [3:0] cnt;
  } exp0_t;

  typedef struct packed {
    logic [4:0] o;
    logic [1:0] st;
  } exp1_t;

  exp0_t q0[$];
  exp1_t q1[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(3), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .pc_en(pc_en0), .if_id_en(if_id_en0),
    .id_ex_en(id_ex_en0), .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0),
    .stall_cnt(stall_cnt0), .state(state0)
  );

  pipeline_ctrl #(.FLUSH_CYCLES(1), .STALL_CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .pc_en(pc_en1), .if_id_en(if_id_en1),
    .id_ex_en(id_ex_en1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .stall_cnt(stall_cnt1), .state(state1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp0(input logic [4:0] o, input logic [1:0] st, input int cnt);
    q0.push_back('{o: o, st: st, cnt: cnt[3:0]});
  endtask

  task automatic exp1(input logic [4:0] o, input logic [1:0] st);
    q1.push_back('{o: o, st: st});
  endtask

  task automatic check_now();
    exp0_t e0;
    exp1_t e1;
    if (q0.size() == 0) begin
      chk("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e0 = q0.pop_front();
      chk("outs", {11'd0, pc_en0, if_id_en0, id_ex_en0, if_id_flush0, id_ex_flush0}, {11'd0, e0.o});
      chk("state", {14'd0, state0}, {14'd0, e0.st});
      chk("stall_cnt", {12'd0, stall_cnt0}, {12'd0, e0.cnt});
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("outs_f1", {11'd0, pc_en1, if_id_en1, id_ex_en1, if_id_flush1, id_ex_flush1}, {11'd0, e1.o});
      chk("state_f1", {14'd0, state1}, {14'd0, e1.st});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_is_load = 0;
    ex_redirect = 0; mdu_start = 0; mdu_done = 0;
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
  endtask

  task automatic set_lu(input logic [4:0] rd, input bit use2);
    idle();
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    if (use2) begin
      id_uses_rs2 = 1; id_rs2 = rd;
    end else begin
      id_uses_rs1 = 1; id_rs1 = rd;
    end
  endtask

  initial begin
    idle();
    // Reset held: hazard still decodes, counter stays 0
    set_lu(5'd5, 0); exp0(O_LU, 2'd0, 0); tick();
    idle(); exp0(O_RUN, 2'd0, 0); tick();
    rst_n = 1;

    set_lu(5'd5, 0); exp0(O_LU, 2'd0, 0); tick();
    idle(); exp0(O_RUN, 2'd0, 1); tick();
    set_lu(5'd7, 1); exp0(O_LU, 2'd0, 1); tick();
    idle(); exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd0, 0); exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd9, 0); id_uses_rs1 = 0; exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd9, 0); ex_is_load = 0; exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd9, 0); id_valid = 0; exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd9, 0); ex_valid = 0; exp0(O_RUN, 2'd0, 2); tick();
    set_lu(5'd9, 0); ex_rd = 5'd10; exp0(O_RUN, 2'd0, 2); tick();
    idle(); mdu_done = 1; exp0(O_RUN, 2'd0, 2); tick();

    // Redirect beats load-use; FLUSH_CYCLES=3 vs 1
    set_lu(5'd3, 0); ex_redirect = 1; exp0(O_RD, 2'd0, 2); exp1(O_RD, 2'd0); tick();
    idle(); mdu_start = 1; exp0(O_FL, 2'd1, 2); exp1(O_FL, 2'd1); tick();
    idle(); exp0(O_FL, 2'd1, 2); exp1(O_RUN, 2'd0); tick();
    exp0(O_FL, 2'd1, 2); exp1(O_RUN, 2'd0); tick();
    exp0(O_RUN, 2'd0, 2); exp1(O_RUN, 2'd0); tick();

    mdu_start = 1; exp0(O_RUN, 2'd0, 2); tick();
    idle();
`ifdef PIPELINE_CTRL_MDU_EN
    for (int k = 0; k < 6; k++) begin
      if (k == 2) set_lu(5'd5, 0);
      exp0(O_MW, 2'd2, 2 + k); tick();
      idle();
    end
    mdu_done = 1; exp0(O_RUN, 2'd2, 8); tick();
    idle(); exp0(O_RUN, 2'd0, 8); tick();
`else
    for (int k = 0; k < 6; k++) begin
      exp0(O_RUN, 2'd0, 2); tick();
    end
    mdu_done = 1; exp0(O_RUN, 2'd0, 2); tick();
    idle(); exp0(O_RUN, 2'd0, 2); tick();
`endif

    // Reset two cycles into MDU_WAIT
    rst_n = 0; exp0(O_RUN, 2'd0, 0); tick();
    rst_n = 1;
    mdu_start = 1; exp0(O_RUN, 2'd0, 0); tick();
    idle();
`ifdef PIPELINE_CTRL_MDU_EN
    exp0(O_MW, 2'd2, 0); tick();
    exp0(O_MW, 2'd2, 1); tick();
`else
    exp0(O_RUN, 2'd0, 0); tick();
    exp0(O_RUN, 2'd0, 0); tick();
`endif
    rst_n = 0; #1;
    exp0(O_RUN, 2'd0, 0); check_now();
    @(posedge clk); #1;
    rst_n = 1;
    exp0(O_RUN, 2'd0, 0); tick();
    exp0(O_RUN, 2'd0, 0); tick();

    // Reset in the middle of a flush
    ex_redirect = 1; exp0(O_RD, 2'd0, 0); tick();
    idle(); exp0(O_FL, 2'd1, 0); tick();
    rst_n = 0; #1;
    exp0(O_RUN, 2'd0, 0); check_now();
    @(posedge clk); #1;
    rst_n = 1;
    exp0(O_RUN, 2'd0, 0); tick();

    // Saturation of the 4-bit counter over 20 stall cycles
    set_lu(5'd4, 0);
    for (int k = 0; k < 20; k++) begin
      exp0(O_LU, 2'd0, (k > 15) ? 15 : k); tick();
    end
    idle(); exp0(O_RUN, 2'd0, 15); tick();
    chk("stall_cnt_w16", stall_cnt1, 16'd20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning: cycles IF/ID flush is held after a redirect (1..15).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning: width of the saturating stall-cycle counter.
REQ-003 SHALL use clock clk and reset rst_n; rst_n is asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 id_valid  input  1  ID stage holds a valid instruction.
REQ-007 id_rs1, id_rs2  input  5 each  ID source register indices.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-009 ex_valid  input  1  EX stage holds a valid instruction.
REQ-010 ex_rd  input  5  EX destination register.
REQ-011 ex_is_load  input  1  EX instruction is a load.
REQ-012 ex_redirect  input  1  branch/jump taken in EX; PC loads target this cycle.
REQ-013 mdu_start, mdu_done  input  1 each  multi-cycle mul/div launched in EX / result ready.
REQ-014 pc_en, if_id_en, id_ex_en  output  1 each  stage-register load enables.
REQ-015 if_id_flush, id_ex_flush  output  1 each  load NOP/zero into IF/ID, ID/EX.
REQ-016 stall_cnt  output  STALL_CNT_W  stall cycles since reset.
REQ-017 state  output  2  current FSM state (RUN=0, FLUSH=1, MDU_WAIT=2).

Function
REQ-018 Outputs SHALL be combinational decodes of state and inputs; state and counters SHALL be registered.
REQ-019 Load-use hazard (lu) SHALL be: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-020 RUN, no event: pc_en=if_id_en=id_ex_en=1, both flushes 0; state stays RUN.
REQ-021 RUN, lu & !ex_redirect: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 (one bubble); state stays RUN.
REQ-022 Any state, ex_redirect: pc_en=1, if_id_flush=1, id_ex_flush=1; next state FLUSH, flush counter loaded with FLUSH_CYCLES-1; redirect SHALL override lu and mdu_start.
REQ-023 FLUSH: enables 1, if_id_flush=1, id_ex_flush=0; counter decrements; exit to RUN when counter is 0 at the clock edge; FLUSH_CYCLES=1 SHALL return to RUN after one FLUSH cycle.
REQ-024 RUN, mdu_start & !ex_redirect: next state MDU_WAIT; outputs this cycle as REQ-020.
REQ-025 MDU_WAIT: pc_en=if_id_en=id_ex_en=0, flushes 0; on mdu_done next state RUN with enables 1 in the mdu_done cycle.
REQ-026 mdu_done outside MDU_WAIT SHALL be ignored; mdu_start outside RUN SHALL be ignored.
REQ-027 stall_cnt SHALL increment each cycle pc_en=0 and saturate at all-ones.

Reset
REQ-028 On rst_n low: state=RUN, flush counter=0, stall_cnt=0, immediately; outputs then decode as RUN (enables follow REQ-020/021).
REQ-029 Reset mid-MDU_WAIT or mid-FLUSH SHALL abandon the operation with no residual stall.

Configuration
REQ-030 Macro PIPELINE_CTRL_MDU_EN defined: MDU_WAIT state and mdu_start/mdu_done SHALL be implemented per REQ-024..026.
REQ-031 Macro undefined: mdu ports SHALL remain present but ignored; MDU_WAIT unreachable; state never 2.

Structure
REQ-032 State encoding enum (RUN, FLUSH, MDU_WAIT) and NOP instruction constant SHALL live in the shared core package.
REQ-033 One sub-module hazard_detect (combinational lu decode, REQ-019) is natural; FSM and counters stay in pipeline_ctrl.

Verification
REQ-034 ex_is_load, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_en=0, id_ex_flush=1, stall_cnt 0->1.
REQ-035 Same as REQ-034 but ex_rd=0 -> no stall, all enables 1.
REQ-036 lu and ex_redirect together, FLUSH_CYCLES=3 -> pc_en=1, both flushes; if_id_flush held 3 further cycles; state RUN after.
REQ-037 mdu_start, mdu_done 6 cycles later (macro defined) -> 6 cycles enables 0, stall_cnt=6; macro undefined -> no stall.
REQ-038 rst_n low 2 cycles into MDU_WAIT -> state=RUN, stall_cnt=0 immediately.
REQ-039 STALL_CNT_W=4, 20 stall cycles -> stall_cnt=15.
